// File: rtl/fir_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fir_config_sequencer
// Brief    : SPI frame receiver writing a shadow coefficient bank that is
//            copied to the live FIR taps only on a sample-boundary strobe.
// Revision : 1.0
// ============================================================================
module fir_config_sequencer #(
    parameter int NUM_TAPS      = 5,
    parameter int COEFF_WIDTH   = 16,
    parameter int CLK_CFG_WIDTH = 2,
    parameter int CLK_CFG_RESET = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            spiClk,
    input  logic                            mosi,
    input  logic                            cs,
    input  logic                            sampleStrobe,
    output logic [NUM_TAPS*COEFF_WIDTH-1:0] coeffs,
    output logic [CLK_CFG_WIDTH-1:0]        clockConfig,
    output logic                            commitPending,
    output logic                            commitDone,
    output logic                            frameError
);

    localparam logic [1:0] S_WAIT_IDLE = 2'd0;
    localparam logic [1:0] S_IDLE      = 2'd1;
    localparam logic [1:0] S_SHIFT     = 2'd2;
    localparam logic [1:0] S_DECODE    = 2'd3;

    localparam logic [7:0] ADDR_CLK    = 8'h40;
    localparam logic [7:0] ADDR_COMMIT = 8'h7F;
    localparam logic [CLK_CFG_WIDTH-1:0] CLK_RST_VAL = CLK_CFG_WIDTH'(CLK_CFG_RESET);

    logic r_sclk_s1, r_sclk_s2, r_sclk_d;
    logic r_mosi_s1, r_mosi_s2;
    logic r_cs_s1, r_cs_s2, r_cs_d;
    logic [1:0]  r_state, w_state_nxt;
    logic [23:0] r_shift;
    logic [4:0]  r_bit_cnt;
    logic [NUM_TAPS*COEFF_WIDTH-1:0] r_shadow, r_live;
    logic [CLK_CFG_WIDTH-1:0]        r_shadow_clk, r_live_clk;
    logic r_pending, r_done, r_err;

    logic w_sclk_rise, w_cs_fall, w_cs_rise;
    logic w_clear, w_shift_en, w_decode, w_frame_ok, w_is_tap;
    logic w_wr_coeff, w_wr_clk, w_commit_req, w_err, w_commit;
    logic [7:0]  w_addr;
    logic [15:0] w_data;
    logic        w_unused;

    // cs synchronisers reset low so a frame live at reset release is never
    // mistaken for an idle bus; WAIT_IDLE waits for a genuine high level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sclk_s1 <= 1'b0; r_sclk_s2 <= 1'b0; r_sclk_d <= 1'b0;
            r_mosi_s1 <= 1'b0; r_mosi_s2 <= 1'b0;
            r_cs_s1   <= 1'b0; r_cs_s2   <= 1'b0; r_cs_d   <= 1'b0;
        end else begin
            r_sclk_s1 <= spiClk; r_sclk_s2 <= r_sclk_s1; r_sclk_d <= r_sclk_s2;
            r_mosi_s1 <= mosi;   r_mosi_s2 <= r_mosi_s1;
            r_cs_s1   <= cs;     r_cs_s2   <= r_cs_s1;   r_cs_d   <= r_cs_s2;
        end
    end

    assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;
    assign w_cs_fall   = ~r_cs_s2 & r_cs_d;
    assign w_cs_rise   = r_cs_s2 & ~r_cs_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_WAIT_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_WAIT_IDLE: if (r_cs_s2)   w_state_nxt = S_IDLE;
            S_IDLE:      if (w_cs_fall) w_state_nxt = S_SHIFT;
            S_SHIFT:     if (w_cs_rise) w_state_nxt = S_DECODE;
            S_DECODE:                   w_state_nxt = S_IDLE;
            default:                    w_state_nxt = S_WAIT_IDLE;
        endcase
    end

    always_comb begin
        w_clear      = (r_state == S_IDLE) && w_cs_fall;
        w_shift_en   = (r_state == S_SHIFT) && w_sclk_rise && !r_cs_s2;
        w_decode     = (r_state == S_DECODE);
        w_frame_ok   = w_decode && (r_bit_cnt == 5'd24);
        w_wr_coeff   = w_frame_ok && w_is_tap;
        w_wr_clk     = w_frame_ok && (w_addr == ADDR_CLK);
        w_commit_req = w_frame_ok && (w_addr == ADDR_COMMIT);
        w_err        = w_decode && !(w_wr_coeff || w_wr_clk || w_commit_req);
    end

    assign w_addr   = r_shift[23:16];
    assign w_data   = r_shift[15:0];
    assign w_is_tap = int'(w_addr) < NUM_TAPS;
    assign w_commit = sampleStrobe && r_pending;
    assign w_unused = ^w_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_clear) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_shift_en) begin
            r_shift   <= {r_shift[22:0], r_mosi_s2};
            r_bit_cnt <= (r_bit_cnt == 5'd31) ? 5'd31 : r_bit_cnt + 5'd1;
        end
    end

    // Live copies sample the shadow before any same-cycle shadow write lands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow     <= '0;
            r_shadow_clk <= CLK_RST_VAL;
            r_live       <= '0;
            r_live_clk   <= CLK_RST_VAL;
            r_pending    <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                if (w_wr_coeff && (int'(w_addr) == i))
                    r_shadow[i*COEFF_WIDTH +: COEFF_WIDTH] <= w_data[COEFF_WIDTH-1:0];
            end
            if (w_wr_clk) r_shadow_clk <= w_data[CLK_CFG_WIDTH-1:0];
            if (w_commit) begin
                r_live     <= r_shadow;
                r_live_clk <= r_shadow_clk;
            end
            if (w_commit_req)  r_pending <= 1'b1;
            else if (w_commit) r_pending <= 1'b0;
            r_done <= w_commit;
            r_err  <= w_err;
        end
    end

    assign coeffs        = r_live;
    assign clockConfig   = r_live_clk;
    assign commitPending = r_pending;
    assign commitDone    = r_done;
    assign frameError    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fir_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_config_sequencer
// Brief    : Randomised SPI stimulus against an array-based shadow/live model.
// Revision : 1.0
// ============================================================================
module tb_fir_config_sequencer;

    localparam int NT = 5;
    localparam int CW = 16;
    localparam int KW = 2;

    logic clk = 1'b0;
    logic reset, spiClk, mosi, cs, sampleStrobe;
    logic [NT*CW-1:0] coeffs;
    logic [KW-1:0]    clockConfig;
    logic             commitPending, commitDone, frameError;

    fir_config_sequencer #(
        .NUM_TAPS(NT), .COEFF_WIDTH(CW), .CLK_CFG_WIDTH(KW), .CLK_CFG_RESET(0)
    ) dut (
        .clk(clk), .reset(reset), .spiClk(spiClk), .mosi(mosi), .cs(cs),
        .sampleStrobe(sampleStrobe), .coeffs(coeffs), .clockConfig(clockConfig),
        .commitPending(commitPending), .commitDone(commitDone), .frameError(frameError)
    );

    always #5 clk = ~clk;

    // Reference model of the register file and commit semantics.
    logic [CW-1:0] m_shadow [NT];
    logic [CW-1:0] m_live   [NT];
    logic [KW-1:0] m_shclk, m_lvclk;
    bit            m_pending;
    int            exp_err, exp_done;
    int            err_cnt, done_cnt;
    int            n_vec, n_err;

    always @(negedge clk) begin
        if (frameError === 1'b1) err_cnt++;
        if (commitDone === 1'b1) done_cnt++;
    end

    function automatic logic [NT*CW-1:0] exp_coeffs();
        logic [NT*CW-1:0] v;
        for (int i = 0; i < NT; i++) v[i*CW +: CW] = m_live[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NT; i++) begin m_shadow[i] = '0; m_live[i] = '0; end
        m_shclk = '0; m_lvclk = '0; m_pending = 0;
    endtask

    task automatic model_frame(input int nbits, input logic [31:0] val);
        int a;
        a = int'(val[23:16]);
        if (nbits != 24)    exp_err++;
        else if (a < NT)    m_shadow[a] = val[15:0];
        else if (a == 'h40) m_shclk = val[KW-1:0];
        else if (a == 'h7F) m_pending = 1;
        else                exp_err++;
    endtask

    task automatic model_strobe();
        if (m_pending) begin
            for (int i = 0; i < NT; i++) m_live[i] = m_shadow[i];
            m_lvclk = m_shclk; m_pending = 0; exp_done++;
        end
    endtask

    task automatic spi_wait(input int n);
        repeat (n) @(posedge clk);
        #($urandom_range(1, 8));
    endtask

    task automatic shift_bits(input int nbits, input logic [31:0] val);
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi = val[i];
            spi_wait(4); spiClk = 1'b1;
            spi_wait(4); spiClk = 1'b0;
        end
    endtask

    task automatic send_frame(input int nbits, input logic [31:0] val, input bit settle);
        cs = 1'b0; spi_wait(4);
        shift_bits(nbits, val);
        spi_wait(4); cs = 1'b1;
        if (settle) begin
            repeat (10) @(posedge clk);
            model_frame(nbits, val);
        end
    endtask

    task automatic pulse_strobe();
        @(negedge clk) sampleStrobe = 1'b1;
        @(negedge clk) sampleStrobe = 1'b0;
        model_strobe();
        repeat (2) @(negedge clk);
    endtask

    task automatic idle_toggle(input int n);
        for (int i = 0; i < n; i++) begin
            mosi = 1'($urandom);
            spi_wait(4); spiClk = 1'b1;
            spi_wait(4); spiClk = 1'b0;
        end
        repeat (6) @(posedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; cs = 1'b1; spiClk = 1'b0; mosi = 1'b0; sampleStrobe = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        n_vec++; if (coeffs !== '0) begin n_err++; $display("FAIL reset_coeffs: got %h want 0", coeffs); end
        n_vec++; if (clockConfig !== 2'd0) begin n_err++; $display("FAIL reset_clk: got %0d want 0", clockConfig); end
        n_vec++; if ({commitPending, commitDone, frameError} !== 3'b000) begin
            n_err++; $display("FAIL reset_flags: got %b want 000", {commitPending, commitDone, frameError}); end
    endtask

    task automatic test_commit();
        send_frame(24, 32'h02_1234, 1);
        send_frame(24, 32'h7F_0000, 1);
        n_vec++; if (coeffs !== exp_coeffs()) begin n_err++; $display("FAIL commit_hold_tap2: got %h want %h", coeffs, exp_coeffs()); end
        n_vec++; if (commitPending !== 1'b1) begin n_err++; $display("FAIL commit_pending_set: got %b want 1", commitPending); end
        pulse_strobe();
        n_vec++; if (coeffs[2*CW +: CW] !== 16'h1234) begin n_err++; $display("FAIL commit_tap2: got %h want 1234", coeffs[2*CW +: CW]); end
        n_vec++; if (done_cnt !== exp_done) begin n_err++; $display("FAIL commit_done: got %0d want %0d", done_cnt, exp_done); end
        n_vec++; if (commitPending !== 1'b0) begin n_err++; $display("FAIL commit_pending_clr: got %b want 0", commitPending); end
    endtask

    task automatic test_bad_frames();
        int e0;
        e0 = err_cnt;
        send_frame(23, 32'h03_4567 >> 1, 1);
        n_vec++; if (err_cnt !== e0 + 1) begin n_err++; $display("FAIL bad_23bit: got %0d want %0d", err_cnt, e0 + 1); end
        send_frame(25, 32'h0_03_4567, 1);
        n_vec++; if (err_cnt !== e0 + 2) begin n_err++; $display("FAIL bad_25bit: got %0d want %0d", err_cnt, e0 + 2); end
        send_frame(24, 32'h05_BEEF, 1);
        n_vec++; if (err_cnt !== e0 + 3) begin n_err++; $display("FAIL bad_addr5: got %0d want %0d", err_cnt, e0 + 3); end
        send_frame(24, 32'h7F_0000, 1);
        pulse_strobe();
        n_vec++; if (coeffs !== exp_coeffs()) begin n_err++; $display("FAIL bad_no_write: got %h want %h", coeffs, exp_coeffs()); end
    endtask

    task automatic test_clk_cfg_collision();
        send_frame(24, 32'h40_0003, 1);
        send_frame(24, 32'h7F_0000, 1);
        pulse_strobe();
        n_vec++; if (clockConfig !== 2'd3) begin n_err++; $display("FAIL clkcfg_3: got %0d want 3", clockConfig); end
        send_frame(24, 32'h7F_0000, 1);
        // cs high sampled at the next edge; DECODE is the cycle ending on the third edge after.
        send_frame(24, 32'h40_0001, 0);
        @(posedge clk); @(posedge clk); @(posedge clk);
        #1 sampleStrobe = 1'b1;
        @(posedge clk);
        #1 sampleStrobe = 1'b0;
        model_strobe();
        model_frame(24, 32'h40_0001);
        repeat (4) @(negedge clk);
        n_vec++; if (clockConfig !== 2'd3) begin n_err++; $display("FAIL clkcfg_collide: got %0d want 3", clockConfig); end
        n_vec++; if (commitPending !== 1'b0) begin n_err++; $display("FAIL clkcfg_collide_pend: got %b want 0", commitPending); end
        send_frame(24, 32'h7F_0000, 1);
        pulse_strobe();
        n_vec++; if (clockConfig !== 2'd1) begin n_err++; $display("FAIL clkcfg_1: got %0d want 1", clockConfig); end
    endtask

    task automatic test_reset_midframe();
        int e0;
        e0 = err_cnt;
        cs = 1'b0; spi_wait(4);
        shift_bits(12, 32'h01_ABCD >> 12);
        reset = 1'b1;
        model_reset();
        spi_wait(3);
        reset = 1'b0;
        shift_bits(12, 32'h01_ABCD);
        spi_wait(4); cs = 1'b1;
        repeat (10) @(negedge clk);
        n_vec++; if (coeffs[CW +: CW] !== 16'h0000) begin n_err++; $display("FAIL midreset_tap1: got %h want 0000", coeffs[CW +: CW]); end
        n_vec++; if (err_cnt !== e0) begin n_err++; $display("FAIL midreset_err: got %0d want %0d", err_cnt, e0); end
        send_frame(24, 32'h01_00FF, 1);
        send_frame(24, 32'h7F_0000, 1);
        pulse_strobe();
        n_vec++; if (coeffs[CW +: CW] !== 16'h00FF) begin n_err++; $display("FAIL midreset_tap1_new: got %h want 00ff", coeffs[CW +: CW]); end
    endtask

    task automatic test_back_to_back();
        int d0;
        for (int a = 0; a < NT; a++) send_frame(24, (a << 16) | (a + 1), 1);
        send_frame(24, 32'h7F_0000, 1);
        send_frame(24, 32'h7F_0000, 1);
        d0 = done_cnt;
        pulse_strobe();
        n_vec++; if (coeffs !== exp_coeffs()) begin n_err++; $display("FAIL b2b_taps: got %h want %h", coeffs, exp_coeffs()); end
        n_vec++; if (done_cnt !== d0 + 1) begin n_err++; $display("FAIL b2b_done1: got %0d want %0d", done_cnt, d0 + 1); end
        pulse_strobe();
        n_vec++; if (done_cnt !== d0 + 1) begin n_err++; $display("FAIL b2b_done2: got %0d want %0d", done_cnt, d0 + 1); end
    endtask

    task automatic test_random();
        int kind, nb;
        logic [31:0] v;
        for (int it = 0; it < 16; it++) begin
            kind = int'($urandom_range(0, 9));
            nb = 24;
            v = {8'h00, $urandom_range(0, NT - 1) & 8'hFF, 16'($urandom)};
            case (kind)
                0: begin nb = ($urandom_range(0, 1) == 0) ? 23 : 25; v = $urandom & 32'h1FF_FFFF; end
                1: v = {8'h00, 8'($urandom_range(NT, 8'h3F)), 16'($urandom)};
                2, 3: v = 32'h7F_0000;
                4: v = {8'h00, 8'h40, 16'($urandom)};
                default: ;
            endcase
            send_frame(nb, v, 1);
            if ($urandom_range(0, 1) == 1) pulse_strobe();
            if ($urandom_range(0, 3) == 0) idle_toggle(3);
            n_vec++; if (coeffs !== exp_coeffs() || clockConfig !== m_lvclk || commitPending !== m_pending
                         || err_cnt !== exp_err || done_cnt !== exp_done) begin
                n_err++;
                $display("FAIL random_%0d: got c=%h k=%0d p=%b e=%0d d=%0d want c=%h k=%0d p=%b e=%0d d=%0d",
                         it, coeffs, clockConfig, commitPending, err_cnt, done_cnt,
                         exp_coeffs(), m_lvclk, m_pending, exp_err, exp_done);
            end
        end
    endtask

    task automatic test_idle_toggle();
        int e0;
        e0 = err_cnt;
        idle_toggle(8);
        send_frame(24, 32'h7F_0000, 1);
        pulse_strobe();
        n_vec++; if (err_cnt !== e0) begin n_err++; $display("FAIL idle_toggle_err: got %0d want %0d", err_cnt, e0); end
        n_vec++; if (coeffs !== exp_coeffs()) begin n_err++; $display("FAIL idle_toggle_taps: got %h want %h", coeffs, exp_coeffs()); end
    endtask

    initial begin
        n_vec = 0; n_err = 0; exp_err = 0; exp_done = 0; err_cnt = 0; done_cnt = 0;
        test_reset();
        test_commit();
        test_bad_frames();
        test_clk_cfg_collision();
        test_reset_midframe();
        test_back_to_back();
        test_idle_toggle();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
